// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizes and filters A/B, emits step/dir per legal
// transition, keeps a loadable up/down position count and a sticky illegal-transition flag.
module quadrature_decoder #(
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_a,
  input  logic         enc_b,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d_in,
  input  logic         err_clr,
  output logic         step,
  output logic         dir,
  output logic [N-1:0] pos,
  output logic         err
);

  localparam int PRIME_LEN = SYNC_STAGES + FILT_LEN;
  localparam int CW        = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
  localparam int PW        = $clog2(PRIME_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [1:0]             ch_f_q, ch_f_d;
  logic [CW-1:0]          cnt_q [2];
  logic [CW-1:0]          cnt_d [2];
  logic [1:0]             prev_q, prev_d;
  logic [PW-1:0]          prime_cnt_q, prime_cnt_d;
  logic                   primed_q, primed_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic [N-1:0]           pos_q, pos_d;
  logic                   err_q, err_d;
  logic [1:0]             ch_s;
  logic                   illegal;

  // Forward sequence is 00 -> 10 -> 11 -> 01 -> 00, with bit 1 = A and bit 0 = B.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      2'b00:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign ch_s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  always_comb begin
    sync_a_d    = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d    = {sync_b_q[SYNC_STAGES-2:0], enc_b};
    ch_f_d      = ch_f_q;
    cnt_d[0]    = cnt_q[0];
    cnt_d[1]    = cnt_q[1];
    prev_d      = prev_q;
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    pos_d       = pos_q;
    err_d       = err_q;
    illegal     = 1'b0;

    if (!primed_q) begin
      // Track the resting encoder state directly so release never looks like motion.
      prime_cnt_d = prime_cnt_q + 1'b1;
      if (prime_cnt_q == PW'(PRIME_LEN - 1)) primed_d = 1'b1;
      ch_f_d   = ch_s;
      prev_d   = ch_s;
      cnt_d[0] = '0;
      cnt_d[1] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ch_s[i] != ch_f_q[i]) begin
          if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
            ch_f_d[i] = ch_s[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
      prev_d = ch_f_q;
      if (ch_f_q != prev_q) begin
        if (ch_f_q == fwd_next(prev_q)) begin
          step_d = 1'b1;
          dir_d  = 1'b1;
        end else if (prev_q == fwd_next(ch_f_q)) begin
          step_d = 1'b1;
          dir_d  = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
    end

    if (err_clr) err_d = 1'b0;
    if (illegal) err_d = 1'b1;

    if (load) begin
      pos_d = d_in;
    end else if (step_d && en) begin
      pos_d = dir_d ? pos_q + 1'b1 : pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a_q    <= '0;
      sync_b_q    <= '0;
      ch_f_q      <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      prev_q      <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      pos_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sync_a_q    <= sync_a_d;
      sync_b_q    <= sync_b_d;
      ch_f_q      <= ch_f_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      prev_q      <= prev_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      err_q       <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign pos  = pos_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed self-checking bench for quadrature_decoder with hand-computed expectations.
module tb_quadrature_decoder;

  logic        clk;
  logic        rst;
  logic        enc_a;
  logic        enc_b;
  logic        en;
  logic        load;
  logic [15:0] d_in;
  logic        err_clr;
  logic        step;
  logic        dir;
  logic [15:0] pos;
  logic        err;

  int errors;
  int checks;
  int steps;
  int first;

  quadrature_decoder #(.N(16), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .en(en), .load(load),
    .d_in(d_in), .err_clr(err_clr), .step(step), .dir(dir), .pos(pos), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive an encoder level and hold it, counting step pulses and the edge of the first one.
  task automatic applyStimulus(input logic a, input logic b, input int cycles,
                               output int n_steps, output int first_edge);
    n_steps    = 0;
    first_edge = 0;
    enc_a      = a;
    enc_b      = b;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      if (step) begin
        n_steps++;
        if (first_edge == 0) first_edge = k;
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    enc_a   = 1'b0;
    enc_b   = 1'b0;
    en      = 1'b1;
    load    = 1'b0;
    d_in    = '0;
    err_clr = 1'b0;

    // Reset held while the encoder toggles
    for (int i = 0; i < 6; i++) begin
      enc_a = i[0];
      enc_b = i[1];
      tick();
    end
    checkOutput("rst_pos", 32'(pos), 32'h0);
    checkOutput("rst_step", 32'(step), 32'h0);
    checkOutput("rst_dir", 32'(dir), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);

    // Release with encoder resting at 11
    enc_a = 1'b1;
    enc_b = 1'b1;
    rst   = 1'b1;
    applyStimulus(1'b1, 1'b1, 15, steps, first);
    checkOutput("prime11_steps", 32'(steps), 32'h0);
    checkOutput("prime11_err", 32'(err), 32'h0);

    // Re-reset and prime at 00
    rst = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 12, steps, first);
    checkOutput("prime00_steps", 32'(steps), 32'h0);

    // Forward sequence
    applyStimulus(1'b1, 1'b0, 10, steps, first);
    checkOutput("fwd_latency", 32'(first), 32'd6);
    checkOutput("fwd1_steps", 32'(steps), 32'd1);
    checkOutput("fwd1_pos", 32'(pos), 32'd1);
    checkOutput("fwd1_dir", 32'(dir), 32'd1);
    applyStimulus(1'b1, 1'b1, 10, steps, first);
    checkOutput("fwd2_steps", 32'(steps), 32'd1);
    applyStimulus(1'b0, 1'b1, 10, steps, first);
    checkOutput("fwd3_steps", 32'(steps), 32'd1);
    applyStimulus(1'b0, 1'b0, 10, steps, first);
    checkOutput("fwd4_steps", 32'(steps), 32'd1);
    checkOutput("fwd_pos", 32'(pos), 32'd4);
    checkOutput("fwd_dir", 32'(dir), 32'd1);
    checkOutput("fwd_err", 32'(err), 32'h0);

    // Load zero, then reverse with wrap
    load = 1'b1;
    d_in = 16'h0000;
    tick();
    load = 1'b0;
    checkOutput("load0_pos", 32'(pos), 32'h0);
    applyStimulus(1'b0, 1'b1, 10, steps, first);
    checkOutput("rev1_steps", 32'(steps), 32'd1);
    checkOutput("rev1_pos", 32'(pos), 32'hFFFF);
    checkOutput("rev1_dir", 32'(dir), 32'd0);
    applyStimulus(1'b1, 1'b1, 10, steps, first);
    applyStimulus(1'b1, 1'b0, 10, steps, first);
    applyStimulus(1'b0, 1'b0, 10, steps, first);
    checkOutput("rev4_steps", 32'(steps), 32'd1);
    checkOutput("rev_pos", 32'(pos), 32'hFFFC);
    checkOutput("rev_dir", 32'(dir), 32'd0);

    // Two-cycle glitch on A is filtered out
    enc_a = 1'b1;
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 10, steps, first);
    checkOutput("glitch_steps", 32'(steps), 32'd0);
    checkOutput("glitch_pos", 32'(pos), 32'hFFFC);
    checkOutput("glitch_err", 32'(err), 32'd0);
    applyStimulus(1'b1, 1'b0, 10, steps, first);
    checkOutput("postglitch_steps", 32'(steps), 32'd1);
    checkOutput("postglitch_pos", 32'(pos), 32'hFFFD);
    checkOutput("postglitch_dir", 32'(dir), 32'd1);

    // Illegal 10 -> 01 sets sticky err
    applyStimulus(1'b0, 1'b1, 10, steps, first);
    checkOutput("illegal_steps", 32'(steps), 32'd0);
    checkOutput("illegal_err", 32'(err), 32'd1);
    checkOutput("illegal_pos", 32'(pos), 32'hFFFD);
    checkOutput("illegal_dir", 32'(dir), 32'd1);
    tick();
    checkOutput("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_clr", 32'(err), 32'd0);

    // Load lands on the step edge: 01 -> 00 forward
    enc_a = 1'b0;
    enc_b = 1'b0;
    steps = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (step) steps++;
    end
    checkOutput("preload_steps", 32'(steps), 32'd0);
    load = 1'b1;
    d_in = 16'h1234;
    tick();
    load = 1'b0;
    checkOutput("load_step", 32'(step), 32'd1);
    checkOutput("load_pos", 32'(pos), 32'h1234);
    checkOutput("load_dir", 32'(dir), 32'd1);
    applyStimulus(1'b0, 1'b0, 4, steps, first);

    // Counting disabled: steps still reported, pos holds
    en = 1'b0;
    applyStimulus(1'b1, 1'b0, 10, steps, first);
    checkOutput("en0_s1", 32'(steps), 32'd1);
    applyStimulus(1'b1, 1'b1, 10, steps, first);
    checkOutput("en0_s2", 32'(steps), 32'd1);
    applyStimulus(1'b0, 1'b1, 10, steps, first);
    checkOutput("en0_s3", 32'(steps), 32'd1);
    checkOutput("en0_pos", 32'(pos), 32'h1234);
    checkOutput("en0_dir", 32'(dir), 32'd1);

    // Mid-run reset clears everything
    rst = 1'b0;
    #2;
    checkOutput("midrst_pos", 32'(pos), 32'h0);
    checkOutput("midrst_dir", 32'(dir), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
